// File: rtl/mx11_ins_mem_resp_if.sv
// mx11_ins_mem_resp_if: instruction MX bus read channel between the mx11 fetch
// master and an instruction memory responder.
//   s_rd_txn_start / s_rd_addr : request level and address (master -> slave)
//   s_rd_txn_ack               : request accepted pulse (slave -> master)
//   s_rd_ready / s_rd_data     : data valid pulse and read byte (slave -> master)
//   s_rd_txn_cpl               : transaction complete pulse (slave -> master)
//   s_rd_err                   : out-of-range completion flag, present only when
//                                MX11_INS_MEM_RESP_ERR_EN is defined
interface mx11_ins_mem_resp_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_rd_txn_start;
    logic [ADDR_WIDTH-1:0] s_rd_addr;
    logic                  s_rd_txn_ack;
    logic                  s_rd_ready;
    logic [DATA_WIDTH-1:0] s_rd_data;
    logic                  s_rd_txn_cpl;
`ifdef MX11_INS_MEM_RESP_ERR_EN
    logic                  s_rd_err;
`endif

    modport slave (
        input  s_rd_txn_start,
        input  s_rd_addr,
        output s_rd_txn_ack,
        output s_rd_ready,
        output s_rd_data,
        output s_rd_txn_cpl
`ifdef MX11_INS_MEM_RESP_ERR_EN
        ,
        output s_rd_err
`endif
    );

    modport master (
        output s_rd_txn_start,
        output s_rd_addr,
        input  s_rd_txn_ack,
        input  s_rd_ready,
        input  s_rd_data,
        input  s_rd_txn_cpl
`ifdef MX11_INS_MEM_RESP_ERR_EN
        ,
        input  s_rd_err
`endif
    );
endinterface

// File: rtl/mx11_ins_mem_resp.sv
// mx11_ins_mem_resp: MX bus read responder serving instruction bytes to the
// mx11 fetch master from an internal byte array.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : slave side of the instruction MX bus (mx11_ins_mem_resp_if)
//   prog_we    : program-load write enable
//   prog_addr  : program-load address
//   prog_data  : program-load data
// Optional feature: define MX11_INS_MEM_RESP_ERR_EN to add bus.s_rd_err, which
// pulses with s_rd_txn_cpl when the read address is at or beyond MEM_DEPTH.
module mx11_ins_mem_resp #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned FILL_VALUE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mx11_ins_mem_resp_if.slave    bus,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [DATA_WIDTH-1:0] FILL      = DATA_WIDTH'(FILL_VALUE);
    localparam logic [CNT_W-1:0]      WAIT_INIT =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT,
        ST_DATA,
        ST_CPL
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  ack_q;
    logic                  ready_q;
    logic                  cpl_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  rd_in_range_c;
    logic                  wr_in_range_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    // Address decode for the latched read and the program-load write
    assign rd_in_range_c = ({1'b0, addr_q} < DEPTH_LIM);
    assign wr_in_range_c = ({1'b0, prog_addr} < DEPTH_LIM);
    assign rd_word_c     = rd_in_range_c ? mem[addr_q[IDX_W-1:0]] : FILL;

    // Program-load port; contents survive reset. The FSM samples mem with the
    // pre-edge value, giving read-before-write on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (prog_we && wr_in_range_c) begin
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    // Transaction FSM; every output is the registered image of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            ready_q  <= 1'b0;
            cpl_q    <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
            cpl_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.s_rd_txn_start) begin
                        addr_q <= bus.s_rd_addr;
                        ack_q  <= 1'b1;
                        state  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (WAIT_STATES == 0) begin
                        data_q  <= rd_word_c;
                        ready_q <= 1'b1;
                        state   <= ST_DATA;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        data_q  <= rd_word_c;
                        ready_q <= 1'b1;
                        state   <= ST_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    cpl_q <= 1'b1;
                    err_q <= ~rd_in_range_c;
                    state <= ST_CPL;
                end
                ST_CPL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_rd_txn_ack = ack_q;
    assign bus.s_rd_ready   = ready_q;
    assign bus.s_rd_data    = data_q;
    assign bus.s_rd_txn_cpl = cpl_q;

`ifdef MX11_INS_MEM_RESP_ERR_EN
    assign bus.s_rd_err = err_q;
`else
    // Out-of-range reads complete silently; the flag has no consumer
    logic err_unused;
    assign err_unused = err_q;
`endif

endmodule

// File: tb/tb_mx11_ins_mem_resp.sv
// tb_mx11_ins_mem_resp: directed bench for mx11_ins_mem_resp.
// DUT a: MEM_DEPTH=128, FILL_VALUE=0xFF, WAIT_STATES=1 (table-driven reads,
// address change, read-before-write, reset mid-transaction).
// DUT b: defaults with WAIT_STATES=0 (back-to-back with start held high).
module tb_mx11_ins_mem_resp;
    logic clk;
    logic rst;

    logic       a_prog_we;
    logic [7:0] a_prog_addr;
    logic [7:0] a_prog_data;
    logic       b_prog_we;
    logic [7:0] b_prog_addr;
    logic [7:0] b_prog_data;

    int n_vec;
    int n_err;

    mx11_ins_mem_resp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) a_if ();
    mx11_ins_mem_resp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b_if ();

    mx11_ins_mem_resp #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(128),
        .WAIT_STATES(1), .FILL_VALUE(255)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(a_if),
        .prog_we(a_prog_we), .prog_addr(a_prog_addr), .prog_data(a_prog_data)
    );

    mx11_ins_mem_resp #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256),
        .WAIT_STATES(0), .FILL_VALUE(0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(b_if),
        .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_data(b_prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic prog_a(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        a_prog_we = 1'b1; a_prog_addr = addr; a_prog_data = data;
        @(negedge clk);
        a_prog_we = 1'b0;
    endtask

    task automatic prog_b(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        b_prog_we = 1'b1; b_prog_addr = addr; b_prog_data = data;
        @(negedge clk);
        b_prog_we = 1'b0;
    endtask

    function automatic logic [31:0] hs_a();
        return 32'({a_if.s_rd_txn_ack, a_if.s_rd_ready, a_if.s_rd_txn_cpl});
    endfunction

    function automatic logic [31:0] hs_b();
        return 32'({b_if.s_rd_txn_ack, b_if.s_rd_ready, b_if.s_rd_txn_cpl});
    endfunction

    // One WAIT_STATES=1 read on DUT a: ack, wait, ready, cpl on cycles 1..4
    task automatic a_read(input logic [7:0] addr, input logic [7:0] exp_data,
                          input logic exp_err, input bit move_addr, input bit rbw,
                          input string name);
        logic [31:0] exp_hs;
        @(negedge clk);
        a_if.s_rd_txn_start = 1'b1;
        a_if.s_rd_addr      = addr;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            exp_hs = (i == 1) ? 32'h4 : (i == 3) ? 32'h2 : (i == 4) ? 32'h1 : 32'h0;
            chk($sformatf("%s hs c%0d", name, i), hs_a(), exp_hs);
            if (i == 3) chk($sformatf("%s data", name), 32'(a_if.s_rd_data), 32'(exp_data));
`ifdef MX11_INS_MEM_RESP_ERR_EN
            chk($sformatf("%s err c%0d", name, i), 32'(a_if.s_rd_err),
                (i == 4) ? 32'(exp_err) : 32'h0);
`endif
            if (i == 1) a_if.s_rd_txn_start = 1'b0;
            if (i == 2 && move_addr) a_if.s_rd_addr = 8'h30;
            if (i == 2 && rbw) begin
                a_prog_we = 1'b1; a_prog_addr = addr; a_prog_data = 8'h5A;
            end
            if (i == 3 && rbw) a_prog_we = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] exp_hs;
        logic [7:0]  dummy;
        n_vec = 0;
        n_err = 0;
        dummy = 8'h0;
        rst = 1'b1;
        a_if.s_rd_txn_start = 1'b0; a_if.s_rd_addr = 8'h0;
        b_if.s_rd_txn_start = 1'b0; b_if.s_rd_addr = 8'h0;
        a_prog_we = 1'b0; a_prog_addr = 8'h0; a_prog_data = 8'h0;
        b_prog_we = 1'b0; b_prog_addr = 8'h0; b_prog_data = 8'h0;

        vecs[0] = '{addr: 8'h10, data: 8'hA5, err: 1'b0};
        vecs[1] = '{addr: 8'h00, data: 8'h3C, err: 1'b0};
        vecs[2] = '{addr: 8'h7F, data: 8'hC3, err: 1'b0};
        vecs[3] = '{addr: 8'h80, data: 8'hFF, err: 1'b1};
        vecs[4] = '{addr: 8'h90, data: 8'hFF, err: 1'b1};
        vecs[5] = '{addr: 8'hFF, data: 8'hFF, err: 1'b1};
        vecs[6] = '{addr: 8'h20, data: 8'h11, err: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset a hs", hs_a(), 32'h0);
        chk("reset a data", 32'(a_if.s_rd_data), 32'h0);
        chk("reset b hs", hs_b(), 32'h0);
        chk("reset b data", 32'(b_if.s_rd_data), 32'h0);
`ifdef MX11_INS_MEM_RESP_ERR_EN
        chk("reset a err", 32'(a_if.s_rd_err), 32'h0);
`endif
        rst = 1'b0;

        // Program DUT a; the write to 0x90 is beyond MEM_DEPTH and must be dropped
        prog_a(8'h10, 8'hA5);
        prog_a(8'h00, 8'h3C);
        prog_a(8'h7F, 8'hC3);
        prog_a(8'h20, 8'h11);
        prog_a(8'h30, 8'h77);
        prog_a(8'h90, 8'h42);

        for (int v = 0; v < 7; v++) begin
            a_read(vecs[v].addr, vecs[v].data, vecs[v].err, 1'b0, 1'b0,
                   $sformatf("vec%0d", v));
        end

        // Address moved to 0x30 during WAIT: data stays mem[0x10], no second ack
        a_read(8'h10, 8'hA5, 1'b0, 1'b1, 1'b0, "addr_move");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("addr_move idle c%0d", i), hs_a(), 32'h0);
        end

        // Write 0x5A to 0x10 on the capture edge: old value first, then new
        a_read(8'h10, 8'hA5, 1'b0, 1'b0, 1'b1, "rbw old");
        a_read(8'h10, 8'h5A, 1'b0, 1'b0, 1'b0, "rbw new");

        // Asynchronous reset during WAIT
        @(negedge clk);
        a_if.s_rd_txn_start = 1'b1;
        a_if.s_rd_addr      = 8'h20;
        @(negedge clk);
        chk("rst_wait ack", hs_a(), 32'h4);
        a_if.s_rd_txn_start = 1'b0;
        @(negedge clk);
        chk("rst_wait held data", 32'(a_if.s_rd_data), 32'h5A);
        #1 rst = 1'b1;
        #1;
        chk("rst_wait hs", hs_a(), 32'h0);
        chk("rst_wait data", 32'(a_if.s_rd_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst quiet c%0d", i), hs_a(), 32'h0);
        end
        a_read(8'h20, 8'h11, 1'b0, 1'b0, 1'b0, "post_rst read");
        a_read(8'h10, 8'h5A, 1'b0, 1'b0, 1'b0, "mem kept");

        // DUT b: WAIT_STATES=0, start held high for two back-to-back reads
        prog_b(8'h20, 8'h11);
        prog_b(8'h21, 8'h22);
        @(negedge clk);
        b_if.s_rd_txn_start = 1'b1;
        b_if.s_rd_addr      = 8'h20;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_hs = (i == 1 || i == 5) ? 32'h4 :
                     (i == 2 || i == 6) ? 32'h2 :
                     (i == 3 || i == 7) ? 32'h1 : 32'h0;
            chk($sformatf("b2b hs c%0d", i), hs_b(), exp_hs);
            if (i == 2) chk("b2b data0", 32'(b_if.s_rd_data), 32'h11);
            if (i == 6) chk("b2b data1", 32'(b_if.s_rd_data), 32'h22);
            if (i == 1) b_if.s_rd_addr = 8'h21;
            if (i == 5) b_if.s_rd_txn_start = 1'b0;
        end
        chk("b2b data held", 32'(b_if.s_rd_data), 32'h22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
